// File: rtl/vreg_load_unit.sv
// Vector load sequencer: fetches W-bit memory words one request at a time, packs them
// into M-bit vectors and writes a burst of vectors into consecutive vector registers.
module vreg_load_unit #(
    parameter int N  = 4,
    parameter int M  = 128,
    parameter int W  = 32,
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [N-1:0]  cmd_vreg,
    input  logic [AW-1:0] cmd_addr,
    input  logic [N-1:0]  cmd_count,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [W-1:0]  mem_rdata,
    output logic          vreg_we,
    output logic [N-1:0]  vreg_addr,
    output logic [M-1:0]  vreg_wdata,
    output logic          busy,
    output logic          done
);

    localparam int B  = M / W;
    localparam int BW = (B > 1) ? $clog2(B) : 1;

    localparam logic [BW-1:0] BEAT_ZERO = {BW{1'b0}};
    localparam logic [BW-1:0] BEAT_ONE  = BW'(1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(B - 1);
    localparam logic [N-1:0]  CNT_ZERO  = {N{1'b0}};
    localparam logic [N-1:0]  CNT_ONE   = N'(1);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic [AW-1:0]  cur_addr_r;
    logic [N-1:0]   cur_vreg_r;
    logic [N-1:0]   cnt_r;
    logic [BW-1:0]  beat_r;
    logic [M-1:0]   pack_r;
    logic           cmd_ready_r;
    logic           mem_req_r;
    logic           vreg_we_r;
    logic           busy_r;
    logic           done_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    if (beat_r == LAST_BEAT) begin
                        state_s = ST_WRITE;
                    end else begin
                        state_s = ST_REQ;
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_WRITE: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Burst bookkeeping and lane packing; the pack register is never cleared between vectors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr_r <= {AW{1'b0}};
            cur_vreg_r <= CNT_ZERO;
            cnt_r      <= CNT_ZERO;
            beat_r     <= BEAT_ZERO;
            pack_r     <= {M{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cur_addr_r <= cmd_addr;
                        cur_vreg_r <= cmd_vreg;
                        cnt_r      <= cmd_count;
                        beat_r     <= BEAT_ZERO;
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        cur_addr_r <= cur_addr_r + ADDR_ONE;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        for (int i = 0; i < B; i++) begin
                            if (beat_r == BW'(i)) begin
                                pack_r[i*W +: W] <= mem_rdata;
                            end
                        end
                        if (beat_r != LAST_BEAT) begin
                            beat_r <= beat_r + BEAT_ONE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (cnt_r != CNT_ZERO) begin
                        cnt_r      <= cnt_r - CNT_ONE;
                        cur_vreg_r <= cur_vreg_r + CNT_ONE;
                        beat_r     <= BEAT_ZERO;
                    end
                end
                default: begin
                    beat_r <= beat_r;
                end
            endcase
        end
    end

    // Control outputs registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready_r <= 1'b0;
            mem_req_r   <= 1'b0;
            vreg_we_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            cmd_ready_r <= (state_s == ST_IDLE);
            mem_req_r   <= (state_s == ST_REQ);
            vreg_we_r   <= (state_s == ST_WRITE);
            busy_r      <= (state_s != ST_IDLE);
            done_r      <= (state_s == ST_DONE);
        end
    end

    assign cmd_ready  = cmd_ready_r;
    assign mem_req    = mem_req_r;
    assign mem_addr   = cur_addr_r;
    assign vreg_we    = vreg_we_r;
    assign vreg_addr  = cur_vreg_r;
    assign vreg_wdata = pack_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: tb/tb_vreg_load_unit.sv
// Scoreboard bench for vreg_load_unit: directed bursts, a memory responder with
// injectable stalls, and monitors that pop expected addresses, writes and done timing.
module tb_vreg_load_unit;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [3:0]   cmd_vreg;
    logic [15:0]  cmd_addr;
    logic [3:0]   cmd_count;
    logic         mem_req;
    logic [15:0]  mem_addr;
    logic         mem_gnt;
    logic         mem_rvalid;
    logic [31:0]  mem_rdata;
    logic         vreg_we;
    logic [3:0]   vreg_addr;
    logic [127:0] vreg_wdata;
    logic         busy;
    logic         done;

    vreg_load_unit #(.N(4), .M(128), .W(32), .AW(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_vreg   (cmd_vreg),
        .cmd_addr   (cmd_addr),
        .cmd_count  (cmd_count),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .vreg_we    (vreg_we),
        .vreg_addr  (vreg_addr),
        .vreg_wdata (vreg_wdata),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   addr;
        logic [127:0] data;
        int           off;
    } wr_t;

    logic [15:0] exp_addr_q[$];
    wr_t         exp_wr_q[$];
    int          exp_done_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int we_cnt = 0;
    int done_cnt = 0;
    int gnt_count = 0;
    int gnt_base = 0;
    int test_id = 0;
    int stall_beat = -1;
    int stall_cycles = 0;
    int rv_beat = -1;
    int rv_delay = 0;
    bit spur_en = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory contents: a hand-set window at 0x100..0x103, an address-derived pattern elsewhere.
    function automatic logic [31:0] mem_word(input logic [15:0] a);
        logic [3:0] n;
        if (a >= 16'h0100 && a <= 16'h0103) begin
            n = {2'b00, a[1:0]} + 4'd1;
            return {8{n}};
        end
        return {a, a ^ 16'hA5A5};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Expected addresses, writes and done timing for a burst from a given start.
    task automatic push_burst(input logic [3:0] v, input logic [15:0] a, input int c, input int extra);
        logic [127:0] vec;
        logic [15:0]  wa;
        wr_t          e;
        for (int k = 0; k <= c; k++) begin
            for (int b = 0; b < 4; b++) begin
                wa = a + 16'(4 * k + b);
                exp_addr_q.push_back(wa);
                vec[b*32 +: 32] = mem_word(wa);
            end
            e.addr = v + 4'(k);
            e.data = vec;
            e.off  = 9 * (k + 1) + extra;
            exp_wr_q.push_back(e);
        end
        exp_done_q.push_back((c + 1) * 9 + 1 + extra);
    endtask

    task automatic send_cmd(input logic [3:0] v, input logic [15:0] a, input logic [3:0] c, input bit keep);
        bit ok;
        ok = 1'b0;
        test_id++;
        gnt_base = gnt_count;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_vreg  = v;
        cmd_addr  = a;
        cmd_count = c;
        for (int t = 0; t < 20; t++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                acc_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("cmd_accept", ok, 1);
        if (!keep) begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input int bound);
        int start;
        start = done_cnt;
        for (int i = 0; i < bound; i++) begin
            if (done_cnt > start) break;
            @(negedge clk);
        end
        chk("done_seen", done_cnt > start, 1);
        @(negedge clk);
    endtask

    task automatic end_test();
        chk("addr_q_empty", exp_addr_q.size(), 0);
        chk("wr_q_empty", exp_wr_q.size(), 0);
        chk("done_q_empty", exp_done_q.size(), 0);
        exp_addr_q.delete();
        exp_wr_q.delete();
        exp_done_q.delete();
    endtask

    // Memory responder: grants, delayed read data, stalls and one spurious rvalid in REQ.
    initial begin
        int   seen_id;
        int   delay_left;
        int   stall_done;
        bit   spur_done;
        bit   awaiting;
        logic [31:0] pend_data;
        seen_id = -1;
        delay_left = 0;
        stall_done = 0;
        spur_done = 1'b0;
        awaiting = 1'b0;
        pend_data = 32'h0;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            if (!rst_n) begin
                awaiting = 1'b0;
                delay_left = 0;
            end else begin
                if (seen_id != test_id) begin
                    seen_id = test_id;
                    stall_done = 0;
                    spur_done = 1'b0;
                end
                if (awaiting) begin
                    if (delay_left > 0) begin
                        delay_left--;
                    end else begin
                        mem_rvalid = 1'b1;
                        mem_rdata = pend_data;
                        awaiting = 1'b0;
                    end
                end else if (mem_req) begin
                    if ((gnt_count - gnt_base) == stall_beat && stall_done < stall_cycles) begin
                        stall_done++;
                        if (exp_addr_q.size() > 0) chk("addr_stall", mem_addr, exp_addr_q[0]);
                        if (spur_en && !spur_done) begin
                            mem_rvalid = 1'b1;
                            mem_rdata = 32'hDEADBEEF;
                            spur_done = 1'b1;
                        end
                    end else begin
                        mem_gnt = 1'b1;
                        if (exp_addr_q.size() == 0) chk("unexpected_req", 1, 0);
                        else chk("mem_addr", mem_addr, exp_addr_q.pop_front());
                        pend_data = mem_word(mem_addr);
                        delay_left = ((gnt_count - gnt_base) == rv_beat) ? rv_delay : 0;
                        gnt_count++;
                        awaiting = 1'b1;
                    end
                end
            end
        end
    end

    // Register-file write monitor.
    always @(negedge clk) begin
        wr_t e;
        if (vreg_we) begin
            we_cnt++;
            if (exp_wr_q.size() == 0) begin
                chk("unexpected_we", 1, 0);
            end else begin
                e = exp_wr_q.pop_front();
                chk("vreg_addr", vreg_addr, e.addr);
                chk("vreg_wdata", vreg_wdata, e.data);
                chk("we_cycle", cyc - acc_cyc, e.off);
            end
        end
    end

    // Done pulse monitor.
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (exp_done_q.size() == 0) chk("unexpected_done", 1, 0);
            else chk("done_cycle", cyc - acc_cyc, exp_done_q.pop_front());
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        wr_t e;
        int  acc1;
        int  we0;
        int  dn0;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_vreg = 4'd0;
        cmd_addr = 16'h0;
        cmd_count = 4'd0;

        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_vreg_we", vreg_we, 0);
        chk("rst_vreg_addr", vreg_addr, 0);
        chk("rst_vreg_wdata", vreg_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", cmd_ready, 1);
        chk("idle_busy", busy, 0);

        // Single vector with hand-computed packing and best-case timing.
        exp_addr_q.push_back(16'h0100);
        exp_addr_q.push_back(16'h0101);
        exp_addr_q.push_back(16'h0102);
        exp_addr_q.push_back(16'h0103);
        e.addr = 4'd3;
        e.data = 128'h44444444_33333333_22222222_11111111;
        e.off  = 9;
        exp_wr_q.push_back(e);
        exp_done_q.push_back(10);
        send_cmd(4'd3, 16'h0100, 4'd0, 1'b0);
        wait_done(100);
        end_test();

        // Register wrap 15 -> 0 -> 1.
        we0 = we_cnt;
        dn0 = done_cnt;
        push_burst(4'd15, 16'h0300, 2, 0);
        send_cmd(4'd15, 16'h0300, 4'd2, 1'b0);
        wait_done(200);
        chk("wrap_we_pulses", we_cnt - we0, 3);
        chk("wrap_done_pulses", done_cnt - dn0, 1);
        end_test();

        // Grant stall on beat 1, read delay on beat 2, spurious rvalid in REQ.
        stall_beat = 1;
        stall_cycles = 3;
        rv_beat = 2;
        rv_delay = 5;
        spur_en = 1'b1;
        push_burst(4'd5, 16'h0400, 0, 8);
        send_cmd(4'd5, 16'h0400, 4'd0, 1'b0);
        wait_done(200);
        stall_beat = -1;
        stall_cycles = 0;
        rv_beat = -1;
        rv_delay = 0;
        spur_en = 1'b0;
        end_test();

        // Memory address wrap.
        exp_addr_q.push_back(16'hFFFE);
        exp_addr_q.push_back(16'hFFFF);
        exp_addr_q.push_back(16'h0000);
        exp_addr_q.push_back(16'h0001);
        e.addr = 4'd9;
        e.data = {mem_word(16'h0001), mem_word(16'h0000), mem_word(16'hFFFF), mem_word(16'hFFFE)};
        e.off  = 9;
        exp_wr_q.push_back(e);
        exp_done_q.push_back(10);
        send_cmd(4'd9, 16'hFFFE, 4'd0, 1'b0);
        wait_done(100);
        end_test();

        // Busy rejection with cmd_valid held and fields changed mid-burst.
        push_burst(4'd2, 16'h0500, 1, 0);
        push_burst(4'd12, 16'h0700, 0, 0);
        send_cmd(4'd2, 16'h0500, 4'd1, 1'b1);
        acc1 = acc_cyc;
        @(negedge clk);
        cmd_vreg = 4'd12;
        cmd_addr = 16'h0700;
        cmd_count = 4'd0;
        for (int t = 1; t <= 19; t++) begin
            chk("busy_ready_low", cmd_ready, 0);
            chk("busy_high", busy, 1);
            @(negedge clk);
        end
        chk("rearm_ready", cmd_ready, 1);
        chk("rearm_cycle", cyc - acc1, 20);
        acc_cyc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_done(100);
        end_test();

        // Reset asserted during WAIT of beat 2.
        rv_beat = 2;
        rv_delay = 10;
        exp_addr_q.push_back(16'h0600);
        exp_addr_q.push_back(16'h0601);
        exp_addr_q.push_back(16'h0602);
        we0 = we_cnt;
        dn0 = done_cnt;
        send_cmd(4'd6, 16'h0600, 4'd1, 1'b0);
        for (int t = 0; t < 40; t++) begin
            if (gnt_count - gnt_base >= 3) break;
            @(negedge clk);
        end
        chk("beat2_granted", (gnt_count - gnt_base) >= 3, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        chk("mid_rst_mem_req", mem_req, 0);
        chk("mid_rst_mem_addr", mem_addr, 0);
        chk("mid_rst_vreg_we", vreg_we, 0);
        chk("mid_rst_vreg_addr", vreg_addr, 0);
        chk("mid_rst_vreg_wdata", vreg_wdata, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rv_beat = -1;
        rv_delay = 0;
        @(negedge clk);
        chk("post_rst_ready", cmd_ready, 1);
        chk("rst_no_we", we_cnt - we0, 0);
        chk("rst_no_done", done_cnt - dn0, 0);
        end_test();
        push_burst(4'd7, 16'h0200, 0, 0);
        send_cmd(4'd7, 16'h0200, 4'd0, 1'b0);
        wait_done(100);
        end_test();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vreg_load_unit.md
# vreg_load_unit

Vector load sequencer that sits directly upstream of the vector register file. It accepts a load command, fetches W-bit words from data memory one request at a time, packs M/W consecutive words into one M-bit vector, and writes each vector through the register file's write port A (we_a / addr_a / data_in_a). It loads a burst of 1..2^N vectors into consecutive vector registers, then pulses done.

## Interface
- N, 4, vector register address width; same as the register file's N
- M, 128, vector width in bits; same as the register file's M
- W, 32, memory word width; M must be an integer multiple of W; B = M/W beats per vector
- AW, 16, memory word-address width
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  load command present
- cmd_ready  out  1  unit can accept a command (high only in IDLE)
- cmd_vreg  in  N  first destination vector register
- cmd_addr  in  AW  word address of the first memory word
- cmd_count  in  N  number of vectors minus 1 (0 → 1 vector, 2^N−1 → 2^N vectors)
- mem_req  out  1  read request
- mem_addr  out  AW  request word address
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  W  read data
- vreg_we  out  1  connects to we_a
- vreg_addr  out  N  connects to addr_a
- vreg_wdata  out  M  connects to data_in_a
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the burst completes

## Operation
- States: IDLE, REQ, WAIT, WRITE, DONE.
- IDLE: cmd_ready=1. When cmd_valid=1, latch cmd_vreg, cmd_addr and cmd_count. Clear beat index b to 0 and go to REQ.
- REQ: mem_req=1 and mem_addr=cur_addr.
  - On mem_gnt=1: cur_addr increments mod 2^AW and the state goes to WAIT.
  - Otherwise stay in REQ with mem_addr held.
- WAIT: mem_req=0. On mem_rvalid=1, store mem_rdata in lane b, bits [(b+1)W−1 : bW]. Beat 0 is the least-significant lane.
  - If b=B−1, go to WRITE. Otherwise b increments and the state returns to REQ.
- mem_rvalid is ignored in all states except WAIT. Only one request is outstanding at a time.
- WRITE: vreg_we=1 for exactly one cycle, with vreg_addr=cur_vreg and vreg_wdata=packed vector.
  - If the remaining count is 0, go to DONE.
  - Otherwise decrement the remaining count, increment cur_vreg mod 2^N (15 wraps to 0), clear b, and go to REQ.
- DONE: done=1 for one cycle, then go to IDLE.
- cmd_valid outside IDLE is ignored; there is no queuing.
- vreg_addr and vreg_wdata may hold stale values when vreg_we=0. The pack register is overwritten lane by lane and is never cleared between vectors.

## Timing
- Reset values: cmd_ready=0 while rst_n=0 and 1 after release (IDLE). mem_req=0, mem_addr=0, vreg_we=0, vreg_addr=0, vreg_wdata=0, busy=0, done=0.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Best case (mem_gnt high in REQ, mem_rvalid in the first WAIT cycle): each beat takes 2 cycles.
  - With the acceptance edge as cycle 0, one vector has vreg_we high in cycle 2B+1. The register file commits the vector at the end of that cycle.
  - done is high in cycle 2B+2. For B=4: vreg_we in cycle 9, done in cycle 10.
- K vectors, best case: K·(2B+1)+1 cycles from acceptance to done.
- mem_gnt stalls and mem_rvalid delays extend REQ and WAIT respectively. They have no other effect.
- Reset asserted mid-burst: immediately return to IDLE with all outputs at reset values. No partial vector is written, and done does not pulse.
- A command accepted in the cycle after DONE is legal: back-to-back bursts.

## Test plan
- Single vector, N=4, M=128, W=32:
  - Stimulus: cmd_vreg=3, cmd_addr=0x0100, cmd_count=0; memory returns 0x11111111, 0x22222222, 0x33333333, 0x44444444.
  - Required: mem_addr sequence 0x100..0x103; vreg_we in cycle 9 with addr 3 and data 0x44444444_33333333_22222222_11111111; done in cycle 10.
- Register wrap:
  - Stimulus: cmd_vreg=15, cmd_count=2.
  - Required: writes to registers 15, 0, 1 from 12 consecutive words; exactly three vreg_we pulses; one done pulse.
- Stall handling:
  - Stimulus: mem_gnt held low for 3 cycles on beat 1; mem_rvalid delayed 5 cycles on beat 2; a spurious mem_rvalid while in REQ.
  - Required: mem_addr stable during the stall; correct packed data; spurious word dropped; done delayed by exactly 8 cycles.
- Address wrap:
  - Stimulus: cmd_addr=0xFFFE, cmd_count=0.
  - Required: mem_addr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Busy rejection:
  - Stimulus: cmd_valid held high throughout a 2-vector burst, with different fields mid-burst.
  - Required: cmd_ready=0 and busy=1 from acceptance to done; the original burst completes unaffected; a new command is accepted the cycle after done.
- Reset mid-op:
  - Stimulus: assert rst_n=0 during WAIT of beat 2.
  - Required: all outputs at reset values immediately; no vreg_we or done pulse; a fresh command after release completes normally.
